// File: rtl/uart_rx_sampler.sv
// UART receive bit sampler: mid-bit sampling of data bits at OVERSAMPLE clk/bit after a start pulse.
// Optional even-parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_sampler #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    input  logic                 d_start_bit,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
`ifdef UART_RX_PARITY_EN
        PARITY = 2'd2,
`endif
        STOP   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   valid_q, ferr_q, busy_q;
    logic                   sample;
`ifdef UART_RX_PARITY_EN
    logic                   perr_q, par_bad_q;
`endif

    always_comb begin
        sample  = (state_q != IDLE) && (tick_q == '0);
        tick_d  = sample ? TW'(OVERSAMPLE - 1) : tick_q - TW'(1);
        shift_d = {data_in, shift_q[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (d_start_bit) begin
                        state_q <= DATA;
                        tick_q  <= TW'(OVERSAMPLE / 2 - 1);
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_bad_q <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    tick_q <= tick_d;
                    if (sample) begin
                        shift_q <= shift_d;
                        bit_q   <= bit_q + BW'(1);
                        if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    tick_q <= tick_d;
                    if (sample) begin
                        // Even parity: line bit must equal XOR of the data bits.
                        par_bad_q <= data_in ^ (^shift_q);
                        state_q   <= STOP;
                    end
                end
`endif
                STOP: begin
                    tick_q <= tick_d;
                    if (sample) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!data_in) begin
                            ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_q) begin
                            perr_q <= 1'b1;
`endif
                        end else begin
                            rx_data_q <= shift_q;
                            valid_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = valid_q;
    assign framing_err = ferr_q;
    assign rx_busy     = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
